// File: rtl/mem_align_unit.sv
// mem_align_unit: byte/halfword/word load-store aligner in front of a word-organised synchronous SRAM.
// Converts core accesses at any byte address into word-aligned RAM cycles with byte enables,
// returns sign/zero-extended load data and stalls the core with busy until the access completes.
// Optional feature macro: MEM_MISALIGNED_SPLIT_EN -- when defined, accesses that cross a word
// boundary are split into two RAM cycles; when undefined they are rejected with accessError.
// Ports:
//   clk, reset (async, active-low)
//   core side: coreAddress, coreDataWrite, coreLength, coreStore, coreLoad, coreLoadUnsigned,
//              coreDataRead, busy, done, accessError
//   RAM side : ramAddress, ramWriteData, ramByteEnable, ramWriteEnable, ramReadEnable, ramReadData
module mem_align_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           coreAddress,
    input  logic [DATA_WIDTH-1:0] coreDataWrite,
    input  logic [1:0]            coreLength,
    input  logic                  coreStore,
    input  logic                  coreLoad,
    input  logic                  coreLoadUnsigned,
    output logic [DATA_WIDTH-1:0] coreDataRead,
    output logic                  busy,
    output logic                  done,
    output logic                  accessError,
    output logic [ADDR_WIDTH-1:0] ramAddress,
    output logic [DATA_WIDTH-1:0] ramWriteData,
    output logic [3:0]            ramByteEnable,
    output logic                  ramWriteEnable,
    output logic                  ramReadEnable,
    input  logic [DATA_WIDTH-1:0] ramReadData
);
`ifdef MEM_MISALIGNED_SPLIT_EN
    localparam bit SplitEn = 1'b1;
`else
    localparam bit SplitEn = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, ACC0, ACC1, COLLECT, DONE} stateType;

    stateType              state, stateNext;
    logic [ADDR_WIDTH+1:0] addrReg;
    logic [31:0]           dataReg, dataLo;
    logic [1:0]            lenReg;
    logic                  unsReg, storeReg, errReg;
    logic                  request, reject, split, inAcc, second;
    logic [ADDR_WIDTH-1:0] word0, word1;
    logic [63:0]           image, aligned;
    logic [7:0]            mask;
    logic [31:0]           loadResult;
    logic                  unusedAddr;

    function automatic logic [2:0] sizeOf(input logic [1:0] len);
        return len == 2'd0 ? 3'd1 : len == 2'd1 ? 3'd2 : 3'd4;
    endfunction

    function automatic logic crosses(input logic [1:0] off, input logic [1:0] len);
        return ({1'b0, off} + sizeOf(len)) > 3'd4;
    endfunction

    // Address bits above the RAM's reach are deliberately ignored.
    assign unusedAddr = ^coreAddress[31:ADDR_WIDTH+2];

    always_comb begin
        request = coreLoad | coreStore;
        reject  = (coreLoad & coreStore) | (coreLength == 2'd2) |
                  (crosses(coreAddress[1:0], coreLength) & ~SplitEn);
        split   = SplitEn & crosses(addrReg[1:0], lenReg);
        word0   = addrReg[ADDR_WIDTH+1:2];
        word1   = word0 + ADDR_WIDTH'(1);
        image   = {32'd0, dataReg} << {addrReg[1:0], 3'b000};
        mask    = {4'd0, lenReg == 2'd0 ? 4'h1 : lenReg == 2'd1 ? 4'h3 : 4'hF} << addrReg[1:0];
        // In COLLECT, ramReadData holds the last word read; dataLo holds word0 of a split load.
        aligned = (split ? {ramReadData, dataLo} : {32'd0, ramReadData}) >> {addrReg[1:0], 3'b000};
        loadResult = lenReg == 2'd0 ? {{24{~unsReg & aligned[7]}}, aligned[7:0]} :
                     lenReg == 2'd1 ? {{16{~unsReg & aligned[15]}}, aligned[15:0]} :
                     aligned[31:0];
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (request) stateNext = reject ? DONE : ACC0;
            ACC0:    stateNext = split ? ACC1 : storeReg ? DONE : COLLECT;
            ACC1:    stateNext = storeReg ? DONE : COLLECT;
            COLLECT: stateNext = DONE;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        inAcc          = (state == ACC0) | (state == ACC1);
        second         = state == ACC1;
        ramWriteEnable = inAcc & storeReg;
        ramReadEnable  = inAcc & ~storeReg;
        ramAddress     = inAcc ? (second ? word1 : word0) : '0;
        ramByteEnable  = ramWriteEnable ? (second ? mask[7:4] : mask[3:0]) : 4'd0;
        ramWriteData   = ramWriteEnable ? (second ? image[63:32] : image[31:0]) : 32'd0;
        done           = state == DONE;
        accessError    = done & errReg;
        // Gated by reset so the core sees no stall while reset is held.
        busy           = reset & (inAcc | (state == COLLECT) | ((state == IDLE) & request));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            addrReg      <= '0;
            dataReg      <= '0;
            dataLo       <= '0;
            lenReg       <= '0;
            unsReg       <= 1'b0;
            storeReg     <= 1'b0;
            errReg       <= 1'b0;
            coreDataRead <= '0;
        end else begin
            state <= stateNext;
            if (state == IDLE && request) begin
                addrReg  <= coreAddress[ADDR_WIDTH+1:0];
                dataReg  <= coreDataWrite;
                lenReg   <= coreLength;
                unsReg   <= coreLoadUnsigned;
                storeReg <= coreStore;
                errReg   <= reject;
            end
            if (state == ACC1) dataLo <= ramReadData;
            if (state == COLLECT) coreDataRead <= loadResult;
        end
    end
endmodule

// File: tb/tb_mem_align_unit.sv
// tb_mem_align_unit: directed and random checks of mem_align_unit against a byte-addressed memory model.
module tb_mem_align_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] coreAddress = '0, coreDataWrite = '0, coreDataRead;
    logic [1:0]  coreLength = '0;
    logic        coreStore = 1'b0, coreLoad = 1'b0, coreLoadUnsigned = 1'b0;
    logic        busy, done, accessError;
    logic [13:0] ramAddress;
    logic [31:0] ramWriteData, ramReadData;
    logic [3:0]  ramByteEnable;
    logic        ramWriteEnable, ramReadEnable;

    logic [31:0] ram [0:16383];
    logic        preload = 1'b0;
    logic [13:0] preIdx = '0;
    logic [31:0] preVal = '0;
    logic [7:0]  refMem [0:65535];
    logic [31:0] expRead;
    logic [13:0] opAddr [2];
    logic [3:0]  opBe [2];
    logic [31:0] opWd [2];
    int checks = 0, errors = 0;
`ifdef MEM_MISALIGNED_SPLIT_EN
    localparam bit SplitOk = 1'b1;
`else
    localparam bit SplitOk = 1'b0;
`endif

    mem_align_unit dut (
        .clk(clk), .reset(reset), .coreAddress(coreAddress), .coreDataWrite(coreDataWrite),
        .coreLength(coreLength), .coreStore(coreStore), .coreLoad(coreLoad),
        .coreLoadUnsigned(coreLoadUnsigned), .coreDataRead(coreDataRead), .busy(busy), .done(done),
        .accessError(accessError), .ramAddress(ramAddress), .ramWriteData(ramWriteData),
        .ramByteEnable(ramByteEnable), .ramWriteEnable(ramWriteEnable), .ramReadEnable(ramReadEnable),
        .ramReadData(ramReadData)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (preload) ram[preIdx] <= preVal;
        else if (ramWriteEnable)
            for (int i = 0; i < 4; i++)
                if (ramByteEnable[i]) ram[ramAddress][8*i +: 8] <= ramWriteData[8*i +: 8];
        ramReadData <= ramReadEnable ? ram[ramAddress] : 32'hA5A5_5A5A;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int sizeOf(input logic [1:0] len);
        return len == 2'd0 ? 1 : len == 2'd1 ? 2 : 4;
    endfunction

    function automatic logic [31:0] modelWord(input int w);
        return {refMem[4*w+3], refMem[4*w+2], refMem[4*w+1], refMem[4*w]};
    endfunction

    task automatic setWord(input int w, input logic [31:0] v);
        @(negedge clk);
        preload = 1'b1; preIdx = 14'(w); preVal = v;
        for (int i = 0; i < 4; i++) refMem[4*w+i] = v[8*i +: 8];
        @(negedge clk);
        preload = 1'b0;
    endtask

    task automatic doAccess(input string tag, input logic st, input logic ld, input logic [31:0] addr,
                            input logic [31:0] data, input logic [1:0] len, input logic uns);
        int size, lat, expLat, ops, expOps, badBusy, badIdle, w0, w1;
        logic expErr, gotDone, errSeen;
        logic [63:0] val, m;
        size    = sizeOf(len);
        expErr  = (st && ld) || len == 2'd2 || ((int'(addr[1:0]) + size > 4) && !SplitOk);
        expOps  = expErr ? 0 : (int'(addr[1:0]) + size > 4) ? 2 : 1;
        expLat  = expErr ? 1 : st ? expOps + 1 : expOps + 2;
        @(negedge clk);
        coreAddress = addr; coreDataWrite = data; coreLength = len;
        coreLoadUnsigned = uns; coreStore = st; coreLoad = ld;
        #1;
        badBusy = busy ? 0 : 1;
        badIdle = done ? 1 : 0;
        lat = 0; ops = 0; gotDone = 1'b0; errSeen = 1'b0;
        while (!gotDone && lat < 12) begin
            @(negedge clk);
            lat++;
            if (done) begin
                gotDone = 1'b1; errSeen = accessError;
                if (busy) badBusy++;
            end else if (!busy) badBusy++;
            if (ramWriteEnable || ramReadEnable) begin
                if (ops < 2) begin opAddr[ops] = ramAddress; opBe[ops] = ramByteEnable; opWd[ops] = ramWriteData; end
                if (ramReadEnable && ramByteEnable != 4'd0) badIdle++;
                ops++;
            end else if (ramAddress != 14'd0 || ramByteEnable != 4'd0 || ramWriteData != 32'd0) badIdle++;
        end
        coreStore = 1'b0; coreLoad = 1'b0;
        check({tag, ".latency"}, 32'(lat), 32'(expLat));
        check({tag, ".error"}, {31'd0, errSeen}, {31'd0, expErr});
        check({tag, ".ramCycles"}, 32'(ops), 32'(expOps));
        check({tag, ".busy"}, 32'(badBusy), 32'd0);
        check({tag, ".quietOutputs"}, 32'(badIdle), 32'd0);
        if (!expErr && st)
            for (int i = 0; i < size; i++) refMem[(int'(addr[15:0]) + i) % 65536] = data[8*i +: 8];
        if (!expErr && ld) begin
            val = 64'd0;
            for (int i = 0; i < size; i++) val[8*i +: 8] = refMem[(int'(addr[15:0]) + i) % 65536];
            m = (64'd1 << (8 * size)) - 64'd1;
            if (!uns && val[8*size-1]) val = val | ~m;
            expRead = val[31:0];
        end
        check({tag, ".coreDataRead"}, coreDataRead, expRead);
        w0 = int'(addr[15:2]);
        w1 = (w0 + 1) % 16384;
        check({tag, ".word0"}, ram[w0], modelWord(w0));
        check({tag, ".word1"}, ram[w1], modelWord(w1));
    endtask

    initial begin
        int bad, r, w, idx, noDone;
        logic [1:0] len;
        expRead = 32'd0;
        repeat (3) @(negedge clk);
        check("reset.outputs", {busy, done, accessError, ramWriteEnable, ramReadEnable, ramByteEnable},
              32'd0);
        check("reset.ram", {ramAddress, 18'd0} | ramWriteData, 32'd0);
        check("reset.coreDataRead", coreDataRead, 32'd0);
        reset = 1'b1;
        for (int i = 0; i < 8; i++) setWord(i, $urandom);
        for (int i = 16376; i < 16384; i++) setWord(i, $urandom);

        doAccess("alignedStore", 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 2'd3, 1'b0);
        check("alignedStore.addr", 32'(opAddr[0]), 32'd4);
        check("alignedStore.be", 32'(opBe[0]), 32'hF);
        check("alignedStore.wd", opWd[0], 32'hDEADBEEF);

        doAccess("preloadW4", 1'b1, 1'b0, 32'h10, 32'h80FF7F01, 2'd3, 1'b0);
        doAccess("byteSigned", 1'b0, 1'b1, 32'h12, 32'h0, 2'd0, 1'b0);
        check("byteSigned.value", coreDataRead, 32'hFFFFFFFF);
        doAccess("byteUnsigned", 1'b0, 1'b1, 32'h12, 32'h0, 2'd0, 1'b1);
        check("byteUnsigned.value", coreDataRead, 32'h000000FF);

        doAccess("splitHalfStore", 1'b1, 1'b0, 32'h13, 32'h0000A1B2, 2'd1, 1'b0);
`ifdef MEM_MISALIGNED_SPLIT_EN
        check("splitHalfStore.addr0", 32'(opAddr[0]), 32'd4);
        check("splitHalfStore.be0", 32'(opBe[0]), 32'h8);
        check("splitHalfStore.wd0", opWd[0], 32'hB2000000);
        check("splitHalfStore.addr1", 32'(opAddr[1]), 32'd5);
        check("splitHalfStore.be1", 32'(opBe[1]), 32'h1);
        check("splitHalfStore.wd1", opWd[1], 32'h000000A1);
`endif

        doAccess("setW4", 1'b1, 1'b0, 32'h10, 32'h44332211, 2'd3, 1'b0);
        doAccess("setW5", 1'b1, 1'b0, 32'h14, 32'h88776655, 2'd3, 1'b0);
        doAccess("splitWordLoad", 1'b0, 1'b1, 32'h11, 32'h0, 2'd3, 1'b0);
`ifdef MEM_MISALIGNED_SPLIT_EN
        check("splitWordLoad.value", coreDataRead, 32'h55443322);
`endif
        doAccess("setTop", 1'b1, 1'b0, 32'hFFFC, 32'hCAFEF00D, 2'd3, 1'b0);
        doAccess("setW0", 1'b1, 1'b0, 32'h0, 32'h13579BDF, 2'd3, 1'b0);
        doAccess("wrapLoad", 1'b0, 1'b1, 32'hFFFD, 32'h0, 2'd3, 1'b1);
        doAccess("wrapHalfStore", 1'b1, 1'b0, 32'h0001FFFF, 32'h00005AA5, 2'd1, 1'b0);

        doAccess("len2Load", 1'b0, 1'b1, 32'h10, 32'h0, 2'd2, 1'b0);
        doAccess("len2Store", 1'b1, 1'b0, 32'h14, 32'h12345678, 2'd2, 1'b0);
        doAccess("bothStrobes", 1'b1, 1'b1, 32'h10, 32'h12345678, 2'd3, 1'b0);

        @(negedge clk);
`ifdef MEM_MISALIGNED_SPLIT_EN
        coreAddress = 32'h13; coreLength = 2'd1; coreDataWrite = 32'h0000C3D4;
`else
        coreAddress = 32'h10; coreLength = 2'd3; coreDataWrite = 32'h12345678;
`endif
        coreStore = 1'b1;
        @(negedge clk);
        check("midReset.inAcc0", {31'd0, ramWriteEnable}, 32'd1);
        #1 reset = 1'b0;
        #1;
        check("midReset.strobes", {30'd0, ramWriteEnable, ramReadEnable}, 32'd0);
        check("midReset.busyDone", {30'd0, busy, done}, 32'd0);
        @(negedge clk);
        coreStore = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        noDone = 0;
        repeat (3) begin @(negedge clk); noDone += int'(done); end
        check("midReset.noDone", 32'(noDone), 32'd0);
        check("midReset.word4", ram[4], modelWord(4));
        check("midReset.word5", ram[5], modelWord(5));
        expRead = 32'd0;
        check("midReset.coreDataRead", coreDataRead, 32'd0);
        doAccess("afterReset", 1'b0, 1'b1, 32'h10, 32'h0, 2'd3, 1'b0);

        for (int n = 0; n < 150; n++) begin
            r   = int'($urandom_range(0, 9));
            len = 2'($urandom_range(0, 3));
            idx = int'($urandom_range(0, 13));
            w   = idx < 7 ? idx : 16377 + idx - 7;
            doAccess("random", r == 0 || r < 5, r == 0 || r >= 5,
                     ($urandom & 32'hFFFF0000) | 32'(w << 2) | 32'($urandom_range(0, 3)),
                     $urandom, len, 1'($urandom_range(0, 1)));
        end

        bad = 0;
        for (int i = 0; i < 8; i++) if (ram[i] !== modelWord(i)) bad++;
        for (int i = 16376; i < 16384; i++) if (ram[i] !== modelWord(i)) bad++;
        check("finalMemory.badWords", 32'(bad), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
